// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the async FIFO read-side controller.
//   ptr_width() : pointer width derived from the address width (one extra
//                 wrap bit so that full and empty can be told apart).
//   bin2gray()  : binary to reflected-gray conversion.
//   gray2bin()  : reflected-gray to binary conversion.
// The conversions work on a 32-bit container. Callers zero-extend narrower
// values and truncate the result. Zero upper bits pass through both
// conversions unchanged.
// Optional feature macro used by the importing files: FIFO_RD_LEVEL_EN.
// -----------------------------------------------------------------------------
package fifo_pkg;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational gray-to-binary converter of parameterized width (WIDTH <= 32).
// The top instantiates it only when FIFO_RD_LEVEL_EN is defined.
// Ports:
//   gray : gray-coded input value
//   bin  : binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(fifo_pkg::gray2bin(32'(gray)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side pointer and flag controller for an asynchronous (gray-pointer)
// FIFO. It keeps a binary read pointer and a gray copy for the write domain.
// It also produces a registered empty flag and an error pulse when a read is
// requested while the FIFO is empty.
//
// Optional feature: define FIFO_RD_LEVEL_EN to build the occupancy output,
// the almost-empty flag and the write-pointer gray-to-binary converter.
//
// Ports:
//   clk            : read-domain clock, rising edge
//   reset_n        : async active-low reset. Release must already be
//                    synchronous to clk.
//   i_rd_en        : read request from the consumer
//   i_wr_ptr_sync  : gray write pointer, already synchronized into clk
//   o_rd_addr      : binary RAM read address (head entry)
//   o_rd_ptr       : gray read pointer for the write domain
//   o_empty        : FIFO empty flag
//   o_rd_err       : one-cycle pulse on a read request while empty
//   o_rd_level     : read-side occupancy        (FIFO_RD_LEVEL_EN only)
//   o_almost_empty : occupancy <= threshold     (FIFO_RD_LEVEL_EN only)
//
// Handshake: i_rd_en acts as valid and !o_empty acts as ready. A read
// transfers on exactly those rising edges where i_rd_en && !o_empty. A
// request seen while o_empty is high is dropped and flagged on o_rd_err.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr_sync,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [ADDR_WIDTH:0]   o_rd_ptr,
    output logic                  o_empty,
    output logic                  o_rd_err
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   o_rd_level,
    output logic                  o_almost_empty
`endif
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic          rd_accept;
    logic          empty_next;
    logic          rd_err_next;

    always_comb begin
        rd_accept    = i_rd_en & ~o_empty;
        // The pointer wraps naturally modulo 2^PW. The MSB is the wrap bit.
        rd_bin_next  = rd_bin + PW'(rd_accept);
        rd_gray_next = PW'(bin2gray(32'(rd_bin_next)));
        // The full-width compare keeps a full FIFO (MSBs differ) from
        // looking empty.
        empty_next   = (rd_gray_next == i_wr_ptr_sync);
        rd_err_next  = i_rd_en & o_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bin   <= '0;
            o_rd_ptr <= '0;
            o_empty  <= 1'b1;
            o_rd_err <= 1'b0;
        end else begin
            rd_bin   <= rd_bin_next;
            o_rd_ptr <= rd_gray_next;
            o_empty  <= empty_next;
            o_rd_err <= rd_err_next;
        end
    end

    // The head entry is always at the low bits of the registered pointer.
    assign o_rd_addr = rd_bin[ADDR_WIDTH-1:0];

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] level_next;

    gray2bin #(
        .WIDTH(PW)
    ) u_wr_gray2bin (
        .gray(i_wr_ptr_sync),
        .bin (wr_bin)
    );

    // Level is computed against the post-read pointer, so it matches the
    // registered o_empty on the same edge.
    assign level_next = wr_bin - rd_bin_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rd_level     <= '0;
            o_almost_empty <= 1'b1;
        end else begin
            o_rd_level     <= level_next;
            o_almost_empty <= (level_next <= AE_THRESH);
        end
    end
`else
    // The threshold only matters when the level logic is built.
    logic [31:0] unused_thresh;
    assign unused_thresh = 32'(ALMOST_EMPTY_THRESH);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Directed self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=4, threshold=2).
// Checks for o_rd_level and o_almost_empty are compiled in only when
// FIFO_RD_LEVEL_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_rd_en = 1'b0;
    logic [4:0] i_wr_ptr_sync = '0;
    logic [3:0] o_rd_addr;
    logic [4:0] o_rd_ptr;
    logic       o_empty;
    logic       o_rd_err;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] o_rd_level;
    logic       o_almost_empty;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];

    fifo_rd_ctrl #(
        .ADDR_WIDTH         (4),
        .ALMOST_EMPTY_THRESH(2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_rd_en       (i_rd_en),
        .i_wr_ptr_sync (i_wr_ptr_sync),
        .o_rd_addr     (o_rd_addr),
        .o_rd_ptr      (o_rd_ptr),
        .o_empty       (o_empty),
        .o_rd_err      (o_rd_err)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .o_rd_level    (o_rd_level),
        .o_almost_empty(o_almost_empty)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        i_rd_en       = 1'b0;
        i_wr_ptr_sync = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        i_rd_en = 1'b0;
        i_wr_ptr_sync = '0;
        tick();
        tick();
        n_checks++; if (o_rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", o_rd_addr); end
        n_checks++; if (o_rd_ptr !== 5'd0) begin n_fail++; $display("FAIL reset_ptr: got %b want 00000", o_rd_ptr); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        n_checks++; if (o_rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_rd_err); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++; if (o_rd_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", o_rd_level); end
        n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", o_almost_empty); end
`endif
    endtask

    // Read requested right at release. It is refused on the first edge and
    // accepted on the second.
    task automatic test_first_read();
        do_reset();
        i_wr_ptr_sync = 5'b00010;
        i_rd_en = 1'b1;
        tick();
        n_checks++; if (o_rd_addr !== 4'd0) begin n_fail++; $display("FAIL first_edge_addr: got %0d want 0", o_rd_addr); end
        n_checks++; if (o_rd_err !== 1'b1) begin n_fail++; $display("FAIL first_edge_err: got %b want 1", o_rd_err); end
        tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_addr !== 4'd1) begin n_fail++; $display("FAIL second_edge_addr: got %0d want 1", o_rd_addr); end
        n_checks++; if (o_rd_err !== 1'b0) begin n_fail++; $display("FAIL second_edge_err: got %b want 0", o_rd_err); end
    endtask

    task automatic test_basic();
        do_reset();
        i_wr_ptr_sync = 5'b00010;
        tick();
        n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL basic_not_empty: got %b want 0", o_empty); end
        i_rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (o_rd_addr !== 4'(i)) begin n_fail++; $display("FAIL basic_addr: got %0d want %0d", o_rd_addr, i); end
        end
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_ptr !== 5'b00010) begin n_fail++; $display("FAIL basic_ptr: got %b want 00010", o_rd_ptr); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_err !== 1'b1) begin n_fail++; $display("FAIL uf_err_pulse: got %b want 1", o_rd_err); end
        n_checks++; if (o_rd_addr !== 4'd0) begin n_fail++; $display("FAIL uf_addr: got %0d want 0", o_rd_addr); end
        n_checks++; if (o_rd_ptr !== 5'd0) begin n_fail++; $display("FAIL uf_ptr: got %b want 00000", o_rd_ptr); end
        tick();
        n_checks++; if (o_rd_err !== 1'b0) begin n_fail++; $display("FAIL uf_err_clear: got %b want 0", o_rd_err); end
        n_checks++; if (o_rd_addr !== 4'd0) begin n_fail++; $display("FAIL uf_addr_hold: got %0d want 0", o_rd_addr); end
    endtask

    task automatic test_full();
        do_reset();
        i_wr_ptr_sync = 5'b11000;
        tick();
        n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL full_not_empty: got %b want 0", o_empty); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++; if (o_rd_level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d want 16", o_rd_level); end
        n_checks++; if (o_almost_empty !== 1'b0) begin n_fail++; $display("FAIL full_ae: got %b want 0", o_almost_empty); end
`endif
        i_rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++; if (o_rd_addr !== 4'(i % 16)) begin n_fail++; $display("FAIL full_addr: got %0d want %0d", o_rd_addr, i % 16); end
            if (i == 15) begin
                n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL full_one_left: got %b want 0", o_empty); end
            end
        end
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_ptr !== 5'b11000) begin n_fail++; $display("FAIL full_ptr: got %b want 11000", o_rd_ptr); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", o_empty); end
    endtask

    task automatic test_level();
        do_reset();
        i_wr_ptr_sync = 5'b00111;    // binary 5
        tick();
        i_rd_en = 1'b1;
        tick();
        tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_addr !== 4'd2) begin n_fail++; $display("FAIL level_addr2: got %0d want 2", o_rd_addr); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++; if (o_rd_level !== 5'd3) begin n_fail++; $display("FAIL level_3: got %0d want 3", o_rd_level); end
        n_checks++; if (o_almost_empty !== 1'b0) begin n_fail++; $display("FAIL level_ae0: got %b want 0", o_almost_empty); end
`endif
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL level_not_empty: got %b want 0", o_empty); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++; if (o_rd_level !== 5'd2) begin n_fail++; $display("FAIL level_2: got %0d want 2", o_rd_level); end
        n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL level_ae1: got %b want 1", o_almost_empty); end
`endif
    endtask

    // Last entry read on the same edge the write pointer advances.
    task automatic test_simultaneous();
        do_reset();
        i_wr_ptr_sync = g(5'd1);
        tick();
        i_rd_en = 1'b1;
        i_wr_ptr_sync = g(5'd2);
        tick();
        n_checks++; if (o_rd_addr !== 4'd1) begin n_fail++; $display("FAIL sim_addr1: got %0d want 1", o_rd_addr); end
        n_checks++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL sim_not_empty: got %b want 0", o_empty); end
        tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_addr !== 4'd2) begin n_fail++; $display("FAIL sim_addr2: got %0d want 2", o_rd_addr); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL sim_empty: got %b want 1", o_empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_wr_ptr_sync = g(5'd10);
        tick();
        i_rd_en = 1'b1;
        repeat (7) tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_rd_addr !== 4'd7) begin n_fail++; $display("FAIL ar_pre_addr: got %0d want 7", o_rd_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (o_rd_addr !== 4'd0) begin n_fail++; $display("FAIL ar_addr: got %0d want 0", o_rd_addr); end
        n_checks++; if (o_rd_ptr !== 5'd0) begin n_fail++; $display("FAIL ar_ptr: got %b want 00000", o_rd_ptr); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty: got %b want 1", o_empty); end
        n_checks++; if (o_rd_err !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", o_rd_err); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++; if (o_rd_level !== 5'd0) begin n_fail++; $display("FAIL ar_level: got %0d want 0", o_rd_level); end
        n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL ar_ae: got %b want 1", o_almost_empty); end
`endif
        tick();
        reset_n = 1'b1;
    endtask

    // Writer advances every cycle for 40 cycles while the reader reads
    // continuously. Each accepted read must move the gray pointer by exactly
    // one bit to the next expected code, including across the wrap.
    task automatic test_back_to_back();
        logic [4:0] prev_ptr;
        logic [4:0] exp_ptr;
        do_reset();
        exp_q.delete();
        for (int k = 1; k <= 40; k++) exp_q.push_back(g(5'(k % 32)));
        prev_ptr = o_rd_ptr;
        i_rd_en = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc < 40) i_wr_ptr_sync = g(5'(cyc + 1));
            tick();
            if (o_rd_ptr !== prev_ptr) begin
                n_checks++; if ($countones(o_rd_ptr ^ prev_ptr) != 1) begin n_fail++; $display("FAIL b2b_one_bit: got %b after %b", o_rd_ptr, prev_ptr); end
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra_read: got ptr %b want no change", o_rd_ptr);
                end else begin
                    exp_ptr = exp_q.pop_front();
                    n_checks++; if (o_rd_ptr !== exp_ptr) begin n_fail++; $display("FAIL b2b_ptr: got %b want %b", o_rd_ptr, exp_ptr); end
                end
            end
            prev_ptr = o_rd_ptr;
        end
        i_rd_en = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_reads: got %0d left want 0", exp_q.size()); end
        n_checks++; if (o_rd_ptr !== 5'b01100) begin n_fail++; $display("FAIL b2b_final_ptr: got %b want 01100", o_rd_ptr); end
        n_checks++; if (o_rd_addr !== 4'd8) begin n_fail++; $display("FAIL b2b_final_addr: got %0d want 8", o_rd_addr); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_final_empty: got %b want 1", o_empty); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_read();
        test_basic();
        test_underflow();
        test_full();
        test_level();
        test_simultaneous();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
